ibex_trace_buffer: RTL

Parametrised retire-trace capture buffer for the ibex core. Attaches to the RVFI retire outputs of the traced top level, stores per-instruction retire records (PC, instruction, rd write, trap/interrupt flags) in an on-chip buffer, and offers them on a valid/ready read port to a debug or test host. Generalises the tracing wrapper with:
- configurable depth
- three capture modes (FIFO, circular, PC-triggered with post-trigger count)
- drop accounting and freeze behaviour

---
 rtl/ibex_trace_buffer_if.sv | 32 +++
 rtl/ibex_trace_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ibex_trace_buffer_if.sv
// Retire-strobe and record read-port bundle for ibex_trace_buffer.
// The buffer sits on the slave side; the traced core plus the host form the master.
interface ibex_trace_buffer_if;
    logic        rvfi_valid;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_insn;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic        rvfi_trap;
    logic        rvfi_intr;

    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_insn;
    logic [31:0] rd_rd_wdata;
    logic [4:0]  rd_rd_addr;
    logic        rd_trap;
    logic        rd_intr;

    modport master (
        output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
               rvfi_trap, rvfi_intr, rd_ready,
        input  rd_valid, rd_pc, rd_insn, rd_rd_wdata, rd_rd_addr, rd_trap, rd_intr
    );

    modport slave (
        input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
               rvfi_trap, rvfi_intr, rd_ready,
        output rd_valid, rd_pc, rd_insn, rd_rd_wdata, rd_rd_addr, rd_trap, rd_intr
    );
endinterface

// File: rtl/ibex_trace_buffer.sv
// Retire-trace capture buffer: stores RVFI retire records with FIFO, circular or
// PC-triggered capture, and offers them on a valid/ready read port.
//
// state   | meaning
// IDLE    | capture off, buffer retained and readable
// CAPTURE | recording every retire, watching for the trigger PC in mode 2
// POST    | trigger seen, recording the post-trigger window
// FROZEN  | window done, capture stopped until disable or clear
module ibex_trace_buffer #(
    parameter int unsigned Depth        = 16,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [1:0]                mode_i,
    input  logic [31:0]               trig_pc_i,
    input  logic [$clog2(Depth):0]    post_trig_i,
    ibex_trace_buffer_if.slave        tr,
    output logic [$clog2(Depth):0]    count_o,
    output logic [DropCntWidth-1:0]   drop_cnt_o,
    output logic                      triggered_o,
    output logic                      frozen_o
);
    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(Depth);

    typedef enum logic [1:0] {IDLE, CAPTURE, POST, FROZEN} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d, post_q, post_d;
    logic [DropCntWidth-1:0] drop_q, drop_d, drop_inc;
    logic                    trig_q, trig_d;
    logic [102:0]            mem_q [Depth];
    logic [102:0]            rec_in, rd_rec;
    logic                    mem_we, push, pop, full, overwrite, trig_hit, rd_valid;

    assign rec_in    = {tr.rvfi_pc_rdata, tr.rvfi_insn, tr.rvfi_rd_addr,
                        tr.rvfi_rd_wdata, tr.rvfi_trap, tr.rvfi_intr};
    assign rd_valid  = (count_q != '0);
    assign push      = tr.rvfi_valid && (state_q == CAPTURE || state_q == POST);
    assign pop       = rd_valid && tr.rd_ready;
    assign full      = (count_q == DepthC);
    assign overwrite = (mode_q == 2'd1) || (mode_q == 2'd2);
    assign trig_hit  = push && (state_q == CAPTURE) && (mode_q == 2'd2)
                       && (tr.rvfi_pc_rdata == trig_pc_i);
    assign drop_inc  = (drop_q == {DropCntWidth{1'b1}}) ? drop_q : drop_q + DropCntWidth'(1);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        drop_d   = drop_q;
        trig_d   = trig_q;
        mem_we   = 1'b0;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            post_d   = '0;
            drop_d   = '0;
            trig_d   = 1'b0;
            if (enable_i && state_q == IDLE) mode_d = mode_i;
            state_d  = enable_i ? CAPTURE : IDLE;
        end else begin
            // Push with pop never overwrites: the pop frees the slot being written.
            if (push && pop) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else if (push) begin
                if (!full) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = count_q + CW'(1);
                end else if (overwrite) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    drop_d   = drop_inc;
                end else begin
                    drop_d   = drop_inc;
                end
            end else if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                count_d  = count_q - CW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_d = CAPTURE;
                        mode_d  = mode_i;
                        trig_d  = 1'b0;
                        post_d  = '0;
                    end
                end
                CAPTURE: begin
                    if (trig_hit) begin
                        trig_d = 1'b1;
                        if (post_trig_i != '0) begin
                            state_d = POST;
                            post_d  = post_trig_i;
                        end else begin
                            state_d = FROZEN;
                        end
                    end
                end
                POST: begin
                    if (push) begin
                        post_d = post_q - CW'(1);
                        if (post_q == CW'(1)) state_d = FROZEN;
                    end
                end
                default: ;
            endcase
            if (!enable_i) state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mode_q   <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            drop_q   <= '0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            drop_q   <= drop_d;
            trig_q   <= trig_d;
        end
    end

    // Record storage needs no reset: the read port masks it while empty.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) mem_q[wr_ptr_q] <= rec_in;
    end

    assign rd_rec         = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign tr.rd_valid    = rd_valid;
    assign tr.rd_pc       = rd_rec[102:71];
    assign tr.rd_insn     = rd_rec[70:39];
    assign tr.rd_rd_addr  = rd_rec[38:34];
    assign tr.rd_rd_wdata = rd_rec[33:2];
    assign tr.rd_trap     = rd_rec[1];
    assign tr.rd_intr     = rd_rec[0];

    assign count_o     = count_q;
    assign drop_cnt_o  = drop_q;
    assign triggered_o = trig_q;
    assign frozen_o    = (state_q == FROZEN);
endmodule
